ray_column_scheduler: RTL and testbench

Per-frame scheduler sitting between the ray engine and the VGA timing generator. During each frame it walks the ray engine through every screen column with a req/ack handshake, saturates each returned wall height, and stores it in the back bank of a double-buffered column-height memory. At frame boundaries it swaps banks so the display path always reads a complete, stable frame of column heights, indexed by the timing generator's column number.

---
 rtl/ray_column_scheduler.sv | 138 +++++++++++++
 tb/tb_ray_column_scheduler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ray_column_scheduler.sv
// ray_column_scheduler
// Walks the ray engine through every screen column once per frame and stores
// the saturated wall heights in the back bank of a double-buffered memory.
// On a frame_tick after the back bank is complete, the banks swap, so the
// display path always reads a complete and stable frame of column heights.
module ray_column_scheduler #(
    parameter int NUM_COLUMNS = 175,
    parameter int COL_W       = 8,
    parameter int HEIGHT_W    = 10,
    parameter int MAX_HEIGHT  = 300
) (
    input  logic                half_clk,
    input  logic                rst,
    input  logic                frame_tick,
    output logic                ray_req,
    output logic [COL_W-1:0]    ray_col,
    input  logic                ray_ack,
    input  logic [HEIGHT_W-1:0] ray_height,
    input  logic [COL_W-1:0]    rd_col,
    output logic [HEIGHT_W-1:0] rd_height,
    output logic                busy,
    output logic                frame_swap,
    output logic                overrun,
    output logic                clamped
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        READY = 2'd2
    } state_t;

    localparam logic [COL_W-1:0]    LAST_COL  = COL_W'(NUM_COLUMNS - 1);
    localparam logic [COL_W:0]      COL_LIMIT = (COL_W + 1)'(NUM_COLUMNS);
    localparam logic [HEIGHT_W-1:0] MAX_H     = HEIGHT_W'(MAX_HEIGHT);
    localparam int                  DEPTH     = 2 ** (COL_W + 1);

    state_t                state_reg;
    logic [COL_W-1:0]      col_reg;
    logic                  front_sel_reg;
    logic                  front_valid_reg;
    logic                  pend_clamp_reg;
    logic                  clamped_reg;
    logic                  frame_swap_reg;
    logic                  overrun_reg;
    logic [HEIGHT_W-1:0]   rd_height_reg;

    // Both banks live in one array; the bank select is the top address bit.
    logic [HEIGHT_W-1:0]   mem [0:DEPTH-1];

    logic                  sat_hit;
    logic [HEIGHT_W-1:0]   sat_height;
    logic                  wr_en;

    assign sat_hit    = (ray_height > MAX_H);
    assign sat_height = sat_hit ? MAX_H : ray_height;
    assign wr_en      = (state_reg == RUN) && ray_ack && !rst;

    assign ray_req    = (state_reg == RUN);
    assign busy       = (state_reg == RUN);
    assign ray_col    = col_reg;
    assign rd_height  = rd_height_reg;
    assign frame_swap = frame_swap_reg;
    assign overrun    = overrun_reg;
    assign clamped    = clamped_reg;

    // Frame FSM: column walk, bank swap, overrun and clamp bookkeeping.
    always_ff @(posedge half_clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            col_reg         <= '0;
            front_sel_reg   <= 1'b0;
            front_valid_reg <= 1'b0;
            pend_clamp_reg  <= 1'b0;
            clamped_reg     <= 1'b0;
            frame_swap_reg  <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            frame_swap_reg <= 1'b0;
            overrun_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (frame_tick) begin
                        col_reg   <= '0;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    // A tick here means the engine is too slow; the frame keeps going.
                    if (frame_tick) begin
                        overrun_reg <= 1'b1;
                    end
                    if (ray_ack) begin
                        if (sat_hit) begin
                            pend_clamp_reg <= 1'b1;
                        end
                        if (col_reg == LAST_COL) begin
                            state_reg <= READY;
                        end else begin
                            col_reg <= col_reg + 1'b1;
                        end
                    end
                end
                READY: begin
                    if (frame_tick) begin
                        front_sel_reg   <= ~front_sel_reg;
                        front_valid_reg <= 1'b1;
                        frame_swap_reg  <= 1'b1;
                        clamped_reg     <= pend_clamp_reg;
                        pend_clamp_reg  <= 1'b0;
                        col_reg         <= '0;
                        state_reg       <= RUN;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Back-bank write port; the front bank is never written.
    always_ff @(posedge half_clk) begin
        if (wr_en) begin
            mem[{~front_sel_reg, col_reg}] <= sat_height;
        end
    end

    // Registered front-bank read; out-of-range columns and an invalid front read 0.
    always_ff @(posedge half_clk) begin
        if (rst) begin
            rd_height_reg <= '0;
        end else if (front_valid_reg && ({1'b0, rd_col} < COL_LIMIT)) begin
            rd_height_reg <= mem[{front_sel_reg, rd_col}];
        end else begin
            rd_height_reg <= '0;
        end
    end

endmodule

// File: tb/tb_ray_column_scheduler.sv
// Directed testbench for ray_column_scheduler: frame walks, swaps, clamping,
// overrun, ack stalls and mid-frame reset, with hand-computed expectations.
module tb_ray_column_scheduler;

    logic       half_clk;
    logic       rst;
    logic       frame_tick;
    logic       ray_req;
    logic [7:0] ray_col;
    logic       ray_ack;
    logic [9:0] ray_height;
    logic [7:0] rd_col;
    logic [9:0] rd_height;
    logic       busy;
    logic       frame_swap;
    logic       overrun;
    logic       clamped;

    int total;
    int bad;

    ray_column_scheduler dut (
        .half_clk   (half_clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .ray_req    (ray_req),
        .ray_col    (ray_col),
        .ray_ack    (ray_ack),
        .ray_height (ray_height),
        .rd_col     (rd_col),
        .rd_height  (rd_height),
        .busy       (busy),
        .frame_swap (frame_swap),
        .overrun    (overrun),
        .clamped    (clamped)
    );

    initial half_clk = 1'b0;
    always #5 half_clk = ~half_clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge half_clk);
        #1;
    endtask

    // Single registered read with expected value.
    task automatic do_read(input int col, input int exp_h);
        rd_col = 8'(col);
        step();
        total++;
        if (rd_height !== 10'(exp_h)) begin
            bad++;
            $display("FAIL read col=%0d got=%0d exp=%0d", col, rd_height, exp_h);
        end
        $display("read col=%0d height=%0d", col, rd_height);
    endtask

    // Swap from READY: tick, then expect a swap pulse and a fresh column walk.
    task automatic do_swap(input bit exp_clamped);
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        total++;
        if (frame_swap !== 1'b1) begin bad++; $display("FAIL swap_pulse got=%0b exp=1", frame_swap); end
        total++;
        if (ray_req !== 1'b1 || ray_col !== 8'd0) begin
            bad++; $display("FAIL swap_restart req=%0b col=%0d exp req=1 col=0", ray_req, ray_col);
        end
        total++;
        if (clamped !== exp_clamped) begin bad++; $display("FAIL swap_clamped got=%0b exp=%0b", clamped, exp_clamped); end
        step();
        total++;
        if (frame_swap !== 1'b0) begin bad++; $display("FAIL swap_single got=%0b exp=0", frame_swap); end
        $display("swap clamped=%0b", clamped);
    endtask

    // Feed one full frame. Height = col+base, except clamp_col which returns 512.
    // tick_at pulses frame_tick alongside that column's ack; stalls inserts idle cycles.
    task automatic run_frame(input int base, input int clamp_col, input int tick_at, input bit stalls);
        int n;
        int errs;
        errs = 0;
        for (int k = 0; k < 175; k++) begin
            if (stalls) begin
                n = int'($urandom_range(0, 7));
                for (int s = 0; s < n; s++) begin
                    ray_ack = 1'b0;
                    step();
                    total++;
                    if (ray_req !== 1'b1 || ray_col !== 8'(k)) begin
                        bad++; errs++;
                        $display("FAIL stall_hold req=%0b col=%0d exp req=1 col=%0d", ray_req, ray_col, k);
                    end
                end
            end
            total++;
            if (ray_req !== 1'b1 || ray_col !== 8'(k) || busy !== 1'b1) begin
                bad++; errs++;
                $display("FAIL col_seq req=%0b busy=%0b col=%0d exp req=1 busy=1 col=%0d", ray_req, busy, ray_col, k);
            end
            ray_ack    = 1'b1;
            ray_height = (k == clamp_col) ? 10'd512 : 10'(k + base);
            frame_tick = (k == tick_at);
            step();
            frame_tick = 1'b0;
            total++;
            if (overrun !== (k == tick_at)) begin
                bad++; errs++;
                $display("FAIL overrun col=%0d got=%0b exp=%0b", k, overrun, (k == tick_at));
            end
            total++;
            if (frame_swap !== 1'b0) begin
                bad++; errs++;
                $display("FAIL no_swap_in_run col=%0d got=%0b exp=0", k, frame_swap);
            end
        end
        ray_ack = 1'b0;
        total++;
        if (ray_req !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL frame_done req=%0b busy=%0b exp 0 0", ray_req, busy);
        end
        step();
        total++;
        if (ray_req !== 1'b0 || frame_swap !== 1'b0 || overrun !== 1'b0) begin
            bad++; $display("FAIL ready_wait req=%0b swap=%0b ovr=%0b exp 0 0 0", ray_req, frame_swap, overrun);
        end
        $display("frame base=%0d clamp_col=%0d tick_at=%0d stalls=%0b errors=%0d", base, clamp_col, tick_at, stalls, errs);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        frame_tick = 1'b0;
        ray_ack = 1'b0;
        ray_height = '0;
        rd_col = '0;
        step();
        step();
        rst = 1'b0;
        step();
        total++;
        if (ray_req !== 1'b0 || ray_col !== 8'd0 || busy !== 1'b0 || frame_swap !== 1'b0 ||
            overrun !== 1'b0 || clamped !== 1'b0 || rd_height !== 10'd0) begin
            bad++;
            $display("FAIL reset_outputs req=%0b col=%0d busy=%0b swap=%0b ovr=%0b clamp=%0b rd=%0d exp all 0",
                     ray_req, ray_col, busy, frame_swap, overrun, clamped, rd_height);
        end
        $display("reset checked");
        do_read(3, 0);
        // Ack while idle must not start anything.
        ray_ack = 1'b1;
        step();
        ray_ack = 1'b0;
        total++;
        if (ray_req !== 1'b0) begin bad++; $display("FAIL idle_ack req=%0b exp=0", ray_req); end
    endtask

    task automatic test_first_frame();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        total++;
        if (ray_req !== 1'b1 || ray_col !== 8'd0 || busy !== 1'b1 || frame_swap !== 1'b0) begin
            bad++;
            $display("FAIL start req=%0b col=%0d busy=%0b swap=%0b exp 1 0 1 0", ray_req, ray_col, busy, frame_swap);
        end
        $display("start frame req=%0b col=%0d", ray_req, ray_col);
        // Front bank is still invalid while the first frame computes.
        do_read(0, 0);
        run_frame(10, -1, -1, 1'b0);
        do_read(0, 0);
    endtask

    task automatic test_swap_read();
        do_swap(1'b0);
        do_read(0, 10);
        do_read(100, 110);
        do_read(174, 184);
        do_read(200, 0);
    endtask

    task automatic test_clamp();
        run_frame(20, 5, -1, 1'b0);
        do_swap(1'b1);
        do_read(5, 300);
        do_read(6, 26);
    endtask

    task automatic test_overrun_mid();
        run_frame(30, -1, 50, 1'b0);
        do_swap(1'b0);
        do_read(5, 35);
        do_read(50, 80);
    endtask

    task automatic test_last_coincident();
        run_frame(40, -1, 174, 1'b0);
        do_read(174, 204);
        do_swap(1'b0);
        do_read(174, 214);
        do_read(200, 0);
    endtask

    task automatic test_stalls_and_reset();
        run_frame(50, -1, -1, 1'b1);
        do_swap(1'b0);
        do_read(100, 150);
        // Start the next frame, ack a few columns, then reset with a tick present.
        for (int k = 0; k < 3; k++) begin
            ray_ack = 1'b1;
            ray_height = 10'(k);
            step();
        end
        ray_ack = 1'b0;
        total++;
        if (ray_col !== 8'd3) begin bad++; $display("FAIL pre_reset_col got=%0d exp=3", ray_col); end
        rst = 1'b1;
        frame_tick = 1'b1;
        step();
        rst = 1'b0;
        frame_tick = 1'b0;
        total++;
        if (ray_req !== 1'b0 || busy !== 1'b0 || ray_col !== 8'd0) begin
            bad++; $display("FAIL midrun_reset req=%0b busy=%0b col=%0d exp 0 0 0", ray_req, busy, ray_col);
        end
        $display("mid-run reset req=%0b", ray_req);
        do_read(100, 0);
        total++;
        if (ray_req !== 1'b0) begin bad++; $display("FAIL reset_stays_idle req=%0b exp=0", ray_req); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_first_frame();
        test_swap_read();
        test_clamp();
        test_overrun_mid();
        test_last_coincident();
        test_stalls_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
